axi_lite_resp_slave: RTL and testbench

AXI4-Lite responder with a bank of `NUM_REGS` 32-bit read/write registers, byte strobes, a configurable read latency and a wrapping write counter. It is the target end of the `simple_axi_master` M00_AXI port. It also serves as the stand-alone slave in the BFM example design, so that the master's write/read/compare sequence has a synthesizable counterpart. The write and read channels are fully independent and may be active in the same cycle.

---
 rtl/axi_lite_resp_slave.sv | 140 ++++++++++++++
 tb/tb_axi_lite_resp_slave.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_resp_slave.sv
// axi_lite_resp_slave: AXI4-Lite register-bank responder with byte strobes, configurable read latency
// and a wrapping write counter. Define AXI_LITE_RESP_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_resp_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [15:0]                     WR_COUNT
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
`ifdef AXI_LITE_RESP_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  // Full index space is allocated so any decoded index is a legal array
  // subscript; entries at or above NUM_REGS are never written and stay zero.
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [2**IW];
  logic [IW-1:0] w_idx_q, r_idx_q, w_idx, r_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, w_data;
  logic [NB-1:0] wstrb_q, w_strb;
  logic [3:0] r_cnt;
  logic aw_hs, w_hs, ar_hs, w_commit, w_ok, r_ok, r_fire;
  logic unused;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  // The commit uses whichever half arrives this cycle, else the latched half.
  assign w_idx = aw_hs ? AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : w_idx_q;
  assign w_data = w_hs ? WDATA : wdata_q;
  assign w_strb = w_hs ? WSTRB : wstrb_q;
  assign w_commit = (aw_hs && w_hs) || (w_state == W_HAVE_A && w_hs) || (w_state == W_HAVE_D && aw_hs);
  assign w_ok = 32'(w_idx) < NUM_REGS;
  assign r_idx = ar_hs ? ARADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_idx_q;
  assign r_ok = 32'(r_idx) < NUM_REGS;
  assign r_fire = (ar_hs && READ_LATENCY == 1) || (r_state == R_WAIT && r_cnt == 4'd1);
  assign unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
  // Write channel: collect AW and W in either order, commit bytes, hold B until accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY <= 1'b1;
      BVALID <= 1'b0;
      BRESP <= 2'b00;
      WR_COUNT <= 16'd0;
      w_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      regs <= '{default: '0};
    end else begin
      if (aw_hs) w_idx_q <= AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (w_commit) begin
        w_state <= W_RESP;
        AWREADY <= 1'b0;
        WREADY <= 1'b0;
        BVALID <= 1'b1;
        BRESP <= w_ok ? 2'b00 : OOR_RESP;
        if (w_ok)
          for (int i = 0; i < NB; i++)
            if (w_strb[i]) regs[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end else if (aw_hs) begin
        w_state <= W_HAVE_A;
        AWREADY <= 1'b0;
      end else if (w_hs) begin
        w_state <= W_HAVE_D;
        WREADY <= 1'b0;
      end else if (BVALID && BREADY) begin
        w_state <= W_IDLE;
        AWREADY <= 1'b1;
        WREADY <= 1'b1;
        BVALID <= 1'b0;
        WR_COUNT <= WR_COUNT + 16'd1;
      end
    end
  end
  // Read channel: count down the latency, sample storage once, hold R until accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID <= 1'b0;
      RDATA <= '0;
      RRESP <= 2'b00;
      r_cnt <= 4'd0;
      r_idx_q <= '0;
    end else begin
      if (ar_hs) begin
        r_idx_q <= ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        ARREADY <= 1'b0;
        r_cnt <= 4'(READ_LATENCY - 1);
      end
      if (r_fire) begin
        r_state <= R_DATA;
        RVALID <= 1'b1;
        RDATA <= r_ok ? regs[r_idx] : '0;
        RRESP <= r_ok ? 2'b00 : OOR_RESP;
      end else if (ar_hs) begin
        r_state <= R_WAIT;
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (RVALID && RREADY) begin
        r_state <= R_IDLE;
        ARREADY <= 1'b1;
        RVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_resp_slave.sv
// tb_axi_lite_resp_slave: randomized bench for axi_lite_resp_slave against a register-array model.
module tb_axi_lite_resp_slave;
  localparam int NREG = 4;
`ifdef AXI_LITE_RESP_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif
  logic ACLK = 0, ARESETN = 0;
  logic [5:0] AWADDR = 0, ARADDR = 0;
  logic AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [31:0] WDATA = 0;
  logic [3:0] WSTRB = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  logic [31:0] RDATA;
  logic [15:0] WR_COUNT;
  logic l_rst_n = 0;
  logic [5:0] l_awaddr = 0, l_araddr = 0;
  logic l_awvalid = 0, l_wvalid = 0, l_bready = 0, l_arvalid = 0, l_rready = 0;
  logic [31:0] l_wdata = 0;
  logic l_awready, l_wready, l_bvalid, l_arready, l_rvalid;
  logic [1:0] l_bresp, l_rresp;
  logic [31:0] l_rdata;
  logic [15:0] l_wr_count;
  int checks = 0, failures = 0;
  logic [31:0] mem [NREG];
  logic [15:0] exp_cnt = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_resp_slave #(.READ_LATENCY(1)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(3'd0), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(3'd0), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .WR_COUNT(WR_COUNT)
  );

  axi_lite_resp_slave #(.READ_LATENCY(4)) dut_lat (
    .ACLK(ACLK), .ARESETN(l_rst_n),
    .AWADDR(l_awaddr), .AWPROT(3'd0), .AWVALID(l_awvalid), .AWREADY(l_awready),
    .WDATA(l_wdata), .WSTRB(4'hf), .WVALID(l_wvalid), .WREADY(l_wready),
    .BRESP(l_bresp), .BVALID(l_bvalid), .BREADY(l_bready),
    .ARADDR(l_araddr), .ARPROT(3'd0), .ARVALID(l_arvalid), .ARREADY(l_arready),
    .RDATA(l_rdata), .RRESP(l_rresp), .RVALID(l_rvalid), .RREADY(l_rready),
    .WR_COUNT(l_wr_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [5:0] a);
    return (a[5:2] < NREG) ? mem[a[5:2]] : 32'd0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [5:0] a);
    return (a[5:2] < NREG) ? 2'b00 : OOR;
  endfunction

  // mode 0: AW and W together; 1: W leads AW by gap cycles; 2: AW leads W by gap cycles
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int gap, input int bp);
    bit aw_done = 0, w_done = 0, af, wf;
    int n = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = (mode != 1); WVALID = (mode != 2);
    while (!(aw_done && w_done) && n < 40) begin
      if (n == gap) begin AWVALID = !aw_done; WVALID = !w_done; end
      af = AWVALID && AWREADY; wf = WVALID && WREADY;
      @(negedge ACLK);
      n++;
      if (af) begin aw_done = 1; AWVALID = 0; end
      if (wf) begin w_done = 1; WVALID = 0; end
      if (!(aw_done && w_done)) check("b_early", {BVALID, aw_done ? AWREADY : WREADY}, 2'b00);
    end
    check("w_handshakes", aw_done && w_done, 1);
    if (a[5:2] < NREG)
      for (int i = 0; i < 4; i++) if (s[i]) mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
    check("b_valid", {BVALID, AWREADY, WREADY, BRESP}, {3'b100, model_resp(a)});
    for (int i = 0; i < bp; i++) begin
      @(negedge ACLK);
      check("b_hold", {BVALID, AWREADY, WREADY, BRESP}, {3'b100, model_resp(a)});
    end
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    exp_cnt++;
    check("b_done", {BVALID, AWREADY, WREADY, WR_COUNT}, {3'b011, exp_cnt});
  endtask

  task automatic do_read(input logic [5:0] a, input int bp);
    logic [31:0] ed;
    logic [1:0] er;
    bit af = 0;
    int n = 0;
    ed = model_rd(a); er = model_resp(a);
    ARADDR = a; ARVALID = 1;
    while (!af && n < 40) begin
      af = ARVALID && ARREADY;
      @(negedge ACLK);
      n++;
    end
    ARVALID = 0;
    check("ar_handshake", af, 1);
    check("r_first", {RVALID, ARREADY, RRESP, RDATA}, {2'b10, er, ed});
    for (int i = 0; i < bp; i++) begin
      @(negedge ACLK);
      check("r_hold", {RVALID, ARREADY, RRESP, RDATA}, {2'b10, er, ed});
    end
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    check("r_done", {RVALID, ARREADY}, 2'b01);
  endtask

  task automatic lat_write(input logic [5:0] a, input logic [31:0] d);
    l_awaddr = a; l_wdata = d; l_awvalid = 1; l_wvalid = 1; l_bready = 1;
    @(negedge ACLK);
    l_awvalid = 0; l_wvalid = 0;
    check("lat_bvalid", l_bvalid, 1);
    @(negedge ACLK);
    l_bready = 0;
  endtask

  task automatic lat_read(input logic [5:0] a, input logic [31:0] d);
    int n = 0;
    check("lat_arready", l_arready, 1);
    l_araddr = a; l_arvalid = 1;
    @(negedge ACLK);
    l_arvalid = 0;
    while (!l_rvalid && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("lat_cycles", n, 3);
    check("lat_rdata", {l_rresp, l_rdata}, {2'b00, d});
    l_rready = 1;
    @(negedge ACLK);
    l_rready = 0;
  endtask

  initial begin
    logic [31:0] d0 [4];
    d0 = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    for (int i = 0; i < NREG; i++) mem[i] = 0;
    repeat (3) @(negedge ACLK);
    check("reset_outs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP},
          {3'b111, 2'b00, 4'h0});
    check("reset_data", {RDATA, WR_COUNT}, 48'd0);
    ARESETN = 1; l_rst_n = 1;
    @(negedge ACLK);
    for (int i = 0; i < 4; i++) do_write(6'(4 * i), d0[i], 4'hf, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(6'(4 * i), 0);
    check("wr_count4", WR_COUNT, 4);
    do_write(6'h08, 32'h11112222, 4'hf, 1, 3, 0);
    do_write(6'h0C, 32'h33334444, 4'hf, 2, 3, 0);
    do_read(6'h08, 0);
    do_read(6'h0C, 0);
    do_write(6'h04, 32'h12345678, 4'b0101, 0, 0, 0);
    check("strobe_model", mem[1], 32'hab340078);
    do_read(6'h04, 0);
    do_write(6'h00, 32'hcafef00d, 4'hf, 0, 0, 5);
    do_read(6'h00, 5);
    do_write(6'h10, 32'hffffffff, 4'hf, 0, 0, 0);
    do_read(6'h10, 0);
    for (int i = 0; i < 4; i++) do_read(6'(4 * i + 1), 0);
    fork
      do_write(6'h08, 32'h5a5a5a5a, 4'hf, 0, 0, 0);
      do_read(6'h08, 0);
    join
    do_read(6'h08, 0);
    for (int k = 0; k < 80; k++) begin
      logic [5:0] a;
      a = 6'(4 * $urandom_range(0, 7) + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end
    lat_write(6'h08, 32'h5a5a1234);
    lat_read(6'h08, 32'h5a5a1234);
    l_araddr = 6'h08; l_arvalid = 1;
    @(negedge ACLK);
    l_arvalid = 0;
    @(negedge ACLK);
    l_rst_n = 0;
    @(negedge ACLK);
    l_rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("lat_rst_rvalid", l_rvalid, 0);
    end
    for (int i = 0; i < 4; i++) lat_read(6'(4 * i), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
